// File: rtl/pci_master.sv
// pci_master: single-initiator PCI burst master.
// Request/grant, one address phase, 1..MAXLEN data phases, one turnaround.
module pci_master #(
    parameter int MAXLEN    = 8,
    parameter int DEVSEL_TO = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  cmd,
    input  logic [31:0] addr,
    input  logic [3:0]  len,
    input  logic [31:0] wr_data,
    output logic        wr_pop,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic        abort,
    output logic [3:0]  xfer_cnt,
    output logic        req_n,
    input  logic        gnt_n,
    input  logic        frame_n_in,
    input  logic        irdy_n_in,
    input  logic        trdy_n,
    input  logic        devsel_n,
    input  logic        stop_n,
    output logic        frame_n,
    output logic        irdy_n,
    output logic        frame_oe,
    output logic        irdy_oe,
    output logic [31:0] ad_out,
    output logic        ad_oe,
    input  logic [31:0] ad_in,
    output logic [3:0]  cbe_n
);
    localparam int DW = $clog2(DEVSEL_TO + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ADDR,
        S_DATA,
        S_TURN
    } state_t;

    state_t      r_state;
    logic        r_write;
    logic [3:0]  r_cmd;
    logic [31:0] r_addr;
    logic [3:0]  r_rem;
    logic [3:0]  r_cnt;
    logic [DW-1:0] r_dcnt;
    logic        r_devsel;
    logic        r_term;
    logic        r_abort;
    logic        r_busy;
    logic        r_done;
    logic        r_req_n;
    logic        r_frame_n;
    logic        r_irdy_n;
    logic        r_frame_oe;
    logic        r_irdy_oe;
    logic        r_ad_oe;
    logic [31:0] r_ad;
    logic [3:0]  r_cbe_n;
    logic [31:0] r_rd_data;
    logic        r_rd_valid;

    logic [3:0]  w_len;
    logic        w_dev;
    logic        w_xfer;

    always_comb begin
        w_len = len;
        if (len == 4'd0)
            w_len = 4'd1;
        else if (len > 4'(MAXLEN))
            w_len = 4'(MAXLEN);
    end

    // DEVSEL# stays claimed once seen, so later phases need not re-check it
    assign w_dev  = r_devsel | ~devsel_n;
    assign w_xfer = (r_state == S_DATA) & ~r_irdy_n & ~trdy_n
                  & w_dev & ~r_term;

    assign wr_pop   = w_xfer & r_write;
    assign ad_out   = (r_state == S_DATA && r_write) ? wr_data : r_ad;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign busy     = r_busy;
    assign done     = r_done;
    assign abort    = r_abort;
    assign xfer_cnt = r_cnt;
    assign req_n    = r_req_n;
    assign frame_n  = r_frame_n;
    assign irdy_n   = r_irdy_n;
    assign frame_oe = r_frame_oe;
    assign irdy_oe  = r_irdy_oe;
    assign ad_oe    = r_ad_oe;
    assign cbe_n    = r_cbe_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_write    <= 1'b0;
            r_cmd      <= 4'd0;
            r_addr     <= 32'd0;
            r_rem      <= 4'd0;
            r_cnt      <= 4'd0;
            r_dcnt     <= '0;
            r_devsel   <= 1'b0;
            r_term     <= 1'b0;
            r_abort    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_req_n    <= 1'b1;
            r_frame_n  <= 1'b1;
            r_irdy_n   <= 1'b1;
            r_frame_oe <= 1'b0;
            r_irdy_oe  <= 1'b0;
            r_ad_oe    <= 1'b0;
            r_ad       <= 32'd0;
            r_cbe_n    <= 4'hF;
            r_rd_data  <= 32'd0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_REQ;
                        r_busy  <= 1'b1;
                        r_req_n <= 1'b0;
                        r_write <= cmd[0];
                        r_cmd   <= cmd;
                        r_addr  <= addr;
                        r_rem   <= w_len;
                        r_cnt   <= 4'd0;
                        r_abort <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (!gnt_n && frame_n_in && irdy_n_in) begin
                        r_state    <= S_ADDR;
                        r_req_n    <= 1'b1;
                        r_frame_n  <= 1'b0;
                        r_frame_oe <= 1'b1;
                        r_ad_oe    <= 1'b1;
                        r_ad       <= r_addr;
                        r_cbe_n    <= r_cmd;
                    end
                end
                S_ADDR: begin
                    r_state   <= S_DATA;
                    r_frame_n <= (r_rem == 4'd1);
                    r_irdy_n  <= 1'b0;
                    r_irdy_oe <= 1'b1;
                    r_ad_oe   <= r_write;
                    r_ad      <= 32'd0;
                    r_cbe_n   <= 4'd0;
                    r_term    <= 1'b0;
                    r_devsel  <= 1'b0;
                    r_dcnt    <= '0;
                end
                S_DATA: begin
                    if (!devsel_n)
                        r_devsel <= 1'b1;
                    if (!w_dev)
                        r_dcnt <= r_dcnt + 1'b1;
                    if (r_term) begin
                        r_state   <= S_TURN;
                        r_frame_n <= 1'b1;
                        r_irdy_n  <= 1'b1;
                    end else if (w_xfer) begin
                        r_cnt <= r_cnt + 4'd1;
                        r_rem <= r_rem - 4'd1;
                        if (!r_write) begin
                            r_rd_data  <= ad_in;
                            r_rd_valid <= 1'b1;
                        end
                        if (r_rem == 4'd1 || !stop_n) begin
                            r_state   <= S_TURN;
                            r_frame_n <= 1'b1;
                            r_irdy_n  <= 1'b1;
                        end else begin
                            r_frame_n <= (r_rem == 4'd2);
                        end
                    end else if (!stop_n && w_dev) begin
                        // disconnect without data: drop FRAME#, keep IRDY# one cycle
                        r_term    <= 1'b1;
                        r_frame_n <= 1'b1;
                    end else if (!w_dev && r_dcnt == DW'(DEVSEL_TO - 1)) begin
                        r_term    <= 1'b1;
                        r_abort   <= 1'b1;
                        r_frame_n <= 1'b1;
                    end
                end
                S_TURN: begin
                    r_state    <= S_IDLE;
                    r_frame_oe <= 1'b0;
                    r_irdy_oe  <= 1'b0;
                    r_ad_oe    <= 1'b0;
                    r_cbe_n    <= 4'hF;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pci_master.sv
// tb_pci_master: randomized PCI target and arbiter stimulus,
// checked against a phase-level transaction model.
module tb_pci_master;
    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [31:0] wr_data;
    logic        wr_pop;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        abort;
    logic [3:0]  xfer_cnt;
    logic        req_n;
    logic        gnt_n;
    logic        frame_n_in;
    logic        irdy_n_in;
    logic        trdy_n;
    logic        devsel_n;
    logic        stop_n;
    logic        frame_n;
    logic        irdy_n;
    logic        frame_oe;
    logic        irdy_oe;
    logic [31:0] ad_out;
    logic        ad_oe;
    logic [31:0] ad_in;
    logic [3:0]  cbe_n;

    int total = 0;
    int bad   = 0;

    pci_master dut (
        .clk(clk), .rst(rst), .start(start), .cmd(cmd), .addr(addr),
        .len(len), .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .done(done), .abort(abort),
        .xfer_cnt(xfer_cnt), .req_n(req_n), .gnt_n(gnt_n),
        .frame_n_in(frame_n_in), .irdy_n_in(irdy_n_in), .trdy_n(trdy_n),
        .devsel_n(devsel_n), .stop_n(stop_n), .frame_n(frame_n),
        .irdy_n(irdy_n), .frame_oe(frame_oe), .irdy_oe(irdy_oe),
        .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in), .cbe_n(cbe_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One transaction: gd/bb/bi = cycles of no grant / busy FRAME# / busy IRDY#,
    // dd = DEVSEL# delay, wt = 2-bit wait count per phase, stop_at = phase with STOP#.
    task automatic run_txn(input bit wr, input logic [3:0] ln,
                           input int stop_at, input bit nodev,
                           input logic [15:0] wt, input bit seq,
                           input int gd, input int bb, input int bi,
                           input int dd);
        logic [31:0] wlist [9];
        logic [31:0] rlist [9];
        logic [31:0] a;
        logic [31:0] pw;
        logic [3:0]  c;
        int L, n, fo, j, ph, wc, wi, et;
        bit xf, pr, pop, fin, fexp;
        L = (ln == 4'd0) ? 1 : ((ln > 4'd8) ? 8 : int'(ln));
        n = nodev ? 0 : ((stop_at > 0 && stop_at < L) ? stop_at : L);
        for (int i = 0; i < 9; i++) begin
            wlist[i] = $urandom;
            rlist[i] = seq ? 32'(32'h11 * (i + 1)) : $urandom;
        end
        a  = $urandom;
        c  = {3'b011, wr};
        fo = gd;
        if (bb > fo) fo = bb;
        if (bi > fo) fo = bi;

        @(posedge clk); #1;
        start   = 1'b1;
        cmd     = c;
        addr    = a;
        len     = ln;
        wi      = 0;
        wr_data = wlist[0];
        for (int k = 0; k <= fo + 1; k++) begin
            @(posedge clk); #1;
            start      = 1'b0;
            gnt_n      = (k < gd);
            frame_n_in = !(k < bb);
            irdy_n_in  = !(k < bi);
            @(negedge clk);
            if (k <= fo) begin
                chk("req_n_low", req_n, 0);
                chk("addr_wait", frame_oe, 0);
                chk("busy", busy, 1);
            end else begin
                chk("addr_frame", frame_n, 0);
                chk("addr_frame_oe", frame_oe, 1);
                chk("addr_ad_oe", ad_oe, 1);
                chk("addr_ad", ad_out, a);
                chk("addr_cbe", cbe_n, c);
                chk("addr_req_n", req_n, 1);
                chk("addr_irdy_oe", irdy_oe, 0);
            end
        end

        j = 0; ph = 0; wc = 0; pr = 0; pop = 0; fin = 0; pw = 0;
        et = nodev ? 6 : -1;
        while (!fin) begin
            @(posedge clk); #1;
            if (pop) wi++;
            pop      = 0;
            wr_data  = wlist[wi];
            start    = (j == 1);
            gnt_n    = 1'($urandom_range(0, 1));
            trdy_n   = 1'b1;
            stop_n   = 1'b1;
            devsel_n = 1'b1;
            ad_in    = $urandom;
            xf       = 0;
            if (ph < n && j >= dd) begin
                devsel_n = 1'b0;
                if (wc < int'(wt[2*ph +: 2])) begin
                    wc++;
                end else begin
                    trdy_n = 1'b0;
                    xf     = 1;
                    if (ph + 1 == stop_at) stop_n = 1'b0;
                    if (!wr) ad_in = rlist[ph];
                end
            end
            @(negedge clk);
            if (et < 0 || j < et) begin
                fexp = nodev ? (L == 1 || j >= 5) : (L - ph == 1);
                chk("data_irdy", irdy_n, 0);
                chk("data_frame", frame_n, fexp);
                chk("data_irdy_oe", irdy_oe, 1);
                chk("data_ad_oe", ad_oe, wr);
                chk("data_cbe", cbe_n, 0);
                chk("wr_pop", wr_pop, xf && wr);
                if (xf && wr) chk("wr_word", ad_out, wlist[ph]);
            end else if (j == et) begin
                chk("turn_frame", frame_n, 1);
                chk("turn_irdy", irdy_n, 1);
                chk("turn_frame_oe", frame_oe, 1);
                chk("turn_irdy_oe", irdy_oe, 1);
                chk("turn_wr_pop", wr_pop, 0);
            end else begin
                chk("done", done, 1);
                chk("abort", abort, nodev);
                chk("xfer_cnt", xfer_cnt, n);
                chk("end_frame_oe", frame_oe, 0);
                chk("end_irdy_oe", irdy_oe, 0);
                chk("end_ad_oe", ad_oe, 0);
                chk("end_busy", busy, 0);
                chk("end_req_n", req_n, 1);
                fin = 1;
            end
            chk("rd_valid", rd_valid, pr);
            if (pr) chk("rd_data", rd_data, pw);
            if (!(et >= 0 && j == et + 1)) chk("done_early", done, 0);
            if (frame_oe && j != et) chk("frame_irdy_idle", frame_n & irdy_n, 0);
            pr = xf && !wr;
            if (xf) begin
                pw = rlist[ph];
                if (wr) pop = 1;
                ph++;
                wc = 0;
                if (ph == n) et = j + 1;
            end
            j++;
            if (!fin && j > 120) begin
                chk("timeout", 0, 1);
                fin = 1;
            end
        end
        start    = 1'b0;
        gnt_n    = 1'b1;
        trdy_n   = 1'b1;
        devsel_n = 1'b1;
        stop_n   = 1'b1;
    endtask

    int mode;

    initial begin
        rst = 1'b0; start = 1'b0; cmd = 4'd0; addr = 32'd0; len = 4'd0;
        wr_data = 32'd0; gnt_n = 1'b1; frame_n_in = 1'b1; irdy_n_in = 1'b1;
        trdy_n = 1'b1; devsel_n = 1'b1; stop_n = 1'b1; ad_in = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_n", req_n, 1);
        chk("rst_frame_n", frame_n, 1);
        chk("rst_irdy_n", irdy_n, 1);
        chk("rst_oes", {frame_oe, irdy_oe, ad_oe}, 0);
        chk("rst_ad_out", ad_out, 0);
        chk("rst_cbe", cbe_n, 4'hF);
        chk("rst_flags", {busy, done, abort, rd_valid, wr_pop}, 0);
        chk("rst_xfer_cnt", xfer_cnt, 0);
        rst = 1'b1;

        run_txn(1, 4'd1, 0, 0, 16'h0000, 0, 2, 0, 0, 0);
        run_txn(0, 4'd4, 0, 0, 16'h0004, 1, 0, 0, 0, 0);
        run_txn(1, 4'd8, 3, 0, 16'h0000, 0, 0, 0, 0, 0);
        run_txn(1, 4'd4, 0, 1, 16'h0000, 0, 0, 0, 0, 0);
        run_txn(0, 4'd2, 0, 0, 16'h0000, 0, 0, 3, 1, 0);
        run_txn(0, 4'd0, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
        run_txn(1, 4'd15, 0, 0, 16'h0000, 0, 1, 0, 0, 0);

        // reset while in DATA
        @(posedge clk); #1;
        start = 1'b1; cmd = 4'b0111; addr = 32'h1234_5678; len = 4'd8;
        gnt_n = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        devsel_n = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_irdy_oe", irdy_oe, 1);
        rst = 1'b0;
        #1;
        chk("arst_oes", {frame_oe, irdy_oe, ad_oe}, 0);
        chk("arst_req_n", req_n, 1);
        chk("arst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b1; devsel_n = 1'b1; gnt_n = 1'b1;
        run_txn(1, 4'd3, 0, 0, 16'h0000, 0, 0, 0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            mode = $urandom_range(0, 9);
            run_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    (mode < 3) ? int'($urandom_range(1, 8)) : 0, mode == 9,
                    16'($urandom), 0, $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 2),
                    $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pci_master.md
# pci_master

Single-initiator PCI bus master that sits directly upstream of the 5-way bus arbiter. It requests the bus on its `req_n` line (one bit of the arbiter's request vector), waits for its `gnt_n`, then runs one burst transaction (address phase plus 1–8 data phases) with full FRAME#/IRDY#/TRDY#/DEVSEL#/STOP# handshaking. It reports completion, master abort or target disconnect to the local user logic.

## Interface

Parameters:
- `MAXLEN`, default 8: maximum data phases per transaction.
- `DEVSEL_TO`, default 5: clocks after the address phase within which `devsel_n` must go low.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse requesting a transaction; ignored while `busy`.
- `cmd` in 4: PCI command, sampled on `start`; `cmd[0]=1` means write.
- `addr` in 32: start address, sampled on `start`.
- `len` in 4: data phases, 1..`MAXLEN`; 0 is treated as 1 and values above `MAXLEN` are clamped.
- `wr_data` in 32: current write word; must be valid while `busy`.
- `wr_pop` out 1: pulses the cycle a write word is transferred.
- `rd_data` out 32: read word.
- `rd_valid` out 1: pulses with each transferred read word.
- `busy` out 1: high from `start` until `done`.
- `done` out 1: one-cycle end-of-transaction pulse.
- `abort` out 1: qualifies `done`; indicates a master abort.
- `xfer_cnt` out 4: phases completed; valid at `done`.
- `req_n` out 1: bus request, to the arbiter.
- `gnt_n` in 1: grant, from the arbiter.
- `frame_n_in`, `irdy_n_in` in 1 each: sampled bus state, used for idle detection.
- `trdy_n`, `devsel_n`, `stop_n` in 1 each: target responses.
- `frame_n`, `irdy_n` out 1 each: driven values.
- `frame_oe`, `irdy_oe` out 1 each: output enables.
- `ad_out` out 32 / `ad_oe` out 1 / `ad_in` in 32: multiplexed address/data.
- `cbe_n` out 4: command in the address phase, 4'b0000 in data phases.

## Operation

State machine: IDLE, REQ, ADDR, DATA, TURN.
- IDLE: on `start`, latch `cmd`/`addr`/`len`, set `busy`, go to REQ.
- REQ: `req_n`=0. When `gnt_n`=0 and the bus is idle (`frame_n_in`=1 and `irdy_n_in`=1) in the same cycle, go to ADDR.
- ADDR, one cycle:
  - `frame_n`=0; `frame_oe`, `ad_oe`=1.
  - `ad_out`=addr; `cbe_n`=cmd.
  - `req_n` returns to 1.
- DATA:
  - `irdy_n`=0, `irdy_oe`=1.
  - Write: `ad_out`=`wr_data` and `ad_oe`=1. Read: `ad_oe`=0.
  - A phase transfers on any cycle with `irdy_n`=0 and `trdy_n`=0.
  - Write transfer: pulse `wr_pop`. Read transfer: capture `ad_in` into `rd_data` and pulse `rd_valid`. Either way, increment the counter.
  - `frame_n` is deasserted (1) during the final phase, i.e. while `remaining==1`; `irdy_n` stays 0 until that phase transfers.
- Termination:
  - Last phase transfers: go to TURN.
  - `stop_n`=0 from the target: end after the current phase (disconnect). `abort`=0 and `xfer_cnt` reports the partial count.
  - No `devsel_n`=0 within `DEVSEL_TO` clocks of ADDR: master abort. Deassert `frame_n`, hold `irdy_n` one more cycle, then TURN with `abort`=1 and no transfers.
- TURN, one cycle:
  - `frame_n`=`irdy_n`=1 with OEs still high (drive inactive).
  - Next cycle all OEs drop, `done` pulses, go to IDLE.
- Grant loss in REQ: stay in REQ. Grant loss after ADDR has no effect; the transaction completes.

## Timing

- Reset outputs: `req_n`=`frame_n`=`irdy_n`=1, all OEs 0, `ad_out`=0, `cbe_n`=4'hF, `busy`=`done`=`abort`=`rd_valid`=`wr_pop`=0, `xfer_cnt`=0.
- Asserting `rst` mid-transaction returns to IDLE immediately, with all OEs 0 asynchronously.
- `req_n` falls the cycle after `start`.
- ADDR begins the cycle after grant and idle are both seen.
- With zero target wait states, an N-phase transaction takes ADDR + N DATA + 1 TURN; `done` pulses on cycle N+3 after leaving REQ.
- `frame_n` and `irdy_n` are never simultaneously 1 while OEs are high, except in TURN.

## Test plan

- Write, `len`=1, `gnt_n` low 2 cycles after `req_n`, target `devsel_n` and `trdy_n` low immediately -> `frame_n` low exactly 1 cycle, one `wr_pop`, `done`, `abort`=0, `xfer_cnt`=1.
- Read, `len`=4, target inserts one TRDY# wait in phase 2, data 0x11,0x22,0x33,0x44 -> 4 `rd_valid` pulses with those values in order; `frame_n` rises with phase 4.
- Write, `len`=8, target asserts `stop_n` during phase 3 -> disconnect after phase 3, `xfer_cnt`=3, `abort`=0.
- No DEVSEL# response -> after 5 clocks `frame_n` rises, `done` with `abort`=1, `xfer_cnt`=0, no `wr_pop`.
- Grant while another master holds `frame_n_in`=0 for 3 cycles -> ADDR delayed until both `frame_n_in` and `irdy_n_in` are 1.
- `rst` low mid-DATA -> all OEs 0 and `req_n`=1 immediately; a new `start` after release completes normally.
